// File: rtl/tick_timer_ctrl.sv
// Programmable divide-by-N tick timer with start/stop/pause, one-shot mode and boundary-safe reloads.
// Optional prescaler enabled by defining TICK_PRESCALE_EN.
module tick_timer_ctrl #(
  parameter int unsigned WIDTH          = 28,
  parameter int unsigned DEFAULT_PERIOD = 32'd50_000_000,
  parameter int unsigned PRESCALE       = 32'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
  output logic             tick,
  output logic             sq_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state,
  output logic [15:0]      tick_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // A zero period would never reach terminal count, so it is promoted to one.
  function automatic logic [WIDTH-1:0] sat_period(input logic [WIDTH-1:0] p);
    sat_period = (p == {WIDTH{1'b0}}) ? ONE : p;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [15:0]      tick_cnt_q, tick_cnt_d;
  logic             mode_q, mode_d;

  logic [WIDTH-1:0] load_val_s;
  logic [WIDTH-1:0] apply_val_s;
  logic             apply_valid_s;
  logic             terminal_s;
  logic             go_s;
  logic             adv_s;

  assign load_val_s    = sat_period(period_in);
  assign apply_val_s   = load ? load_val_s : pend_q;
  assign apply_valid_s = load | pend_valid_q;
  assign terminal_s    = (cnt_q == (period_q - ONE));
  assign go_s          = start & ~stop & ~pause;

`ifdef TICK_PRESCALE_EN
  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 32'd1);

  logic [7:0] pre_q, pre_d;

  assign adv_s = (pre_q == PRE_LAST);

  // Prescaler: restarts on a fresh start or a stop, frozen while paused.
  always_comb begin
    pre_d = pre_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go_s) pre_d = 8'd0;
        else      pre_d = pre_q;
      end
      ST_RUN: begin
        if (stop)       pre_d = 8'd0;
        else if (pause) pre_d = pre_q;
        else if (adv_s) pre_d = 8'd0;
        else            pre_d = pre_q + 8'd1;
      end
      ST_PAUSE: begin
        if (stop) pre_d = 8'd0;
        else      pre_d = pre_q;
      end
      default: pre_d = 8'd0;
    endcase
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= 8'd0;
    else        pre_q <= pre_d;
  end
`else
  assign adv_s = 1'b1;
`endif

  // Next-state, counter, period-reload and output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    tick_d       = 1'b0;
    tick_cnt_d   = tick_cnt_q;
    mode_d       = mode_q;
    sq_d         = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load) period_d = load_val_s;
        else      period_d = period_q;
        if (go_s) begin
          state_d    = ST_RUN;
          cnt_d      = {WIDTH{1'b0}};
          tick_cnt_d = 16'd0;
          mode_d     = oneshot;
        end else if (stop) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        // While busy, loads collect in the pending slot until a wrap or stop.
        pend_d       = apply_val_s;
        pend_valid_d = apply_valid_s;
        if (stop) begin
          state_d      = ST_IDLE;
          cnt_d        = {WIDTH{1'b0}};
          period_d     = apply_valid_s ? apply_val_s : period_q;
          pend_valid_d = 1'b0;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else if (adv_s && terminal_s) begin
          cnt_d        = {WIDTH{1'b0}};
          tick_d       = 1'b1;
          tick_cnt_d   = tick_cnt_q + 16'd1;
          period_d     = apply_valid_s ? apply_val_s : period_q;
          pend_valid_d = 1'b0;
          state_d      = mode_q ? ST_DONE : ST_RUN;
        end else if (adv_s) begin
          cnt_d = cnt_q + ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_PAUSE: begin
        pend_d       = apply_val_s;
        pend_valid_d = apply_valid_s;
        if (stop) begin
          state_d      = ST_IDLE;
          cnt_d        = {WIDTH{1'b0}};
          period_d     = apply_valid_s ? apply_val_s : period_q;
          pend_valid_d = 1'b0;
        end else if (!pause && start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_RUN:   sq_d = (cnt_d < (period_d >> 1)) || (period_d == ONE);
      ST_PAUSE: sq_d = sq_q;
      default:  sq_d = 1'b0;
    endcase
  end

  assign busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
  assign done_d = (state_d == ST_DONE);

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {WIDTH{1'b0}};
      period_q     <= WIDTH'(DEFAULT_PERIOD);
      pend_q       <= {WIDTH{1'b0}};
      pend_valid_q <= 1'b0;
      tick_q       <= 1'b0;
      sq_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tick_cnt_q   <= 16'd0;
      mode_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      tick_q       <= tick_d;
      sq_q         <= sq_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      tick_cnt_q   <= tick_cnt_d;
      mode_q       <= mode_d;
    end
  end

  assign tick     = tick_q;
  assign sq_out   = sq_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign state    = state_q;
  assign tick_cnt = tick_cnt_q;

endmodule

// File: doc/tick_timer_ctrl.md
Name: tick_timer_ctrl

Overview:
- Programmable timer controller that sequences a divide-by-N counter.
- Supports start, stop, pause/resume, one-shot and periodic modes, and glitch-free period reconfiguration at period boundaries.
- Produces a one-cycle tick pulse, a ~50% square output and status for downstream logic such as display refresh, debouncers and second counters.

Parameters:
WIDTH, 28, width of the period register and cycle counter
DEFAULT_PERIOD, 50_000_000, period_r value after reset (clk cycles per tick)
PRESCALE, 1, clk cycles per counter advance; used only when TICK_PRESCALE_EN is defined; legal range 1..255

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  start, resume or restart request (level, sampled each edge)
stop  input  1  stop request; returns to IDLE
pause  input  1  freeze the counter while in RUN
oneshot  input  1  mode select, latched on start from IDLE/DONE: 1 = one tick then DONE
load  input  1  period load strobe
period_in  input  WIDTH  new period in cycles; 0 is treated as 1
tick  output  1  registered single-cycle pulse at each period end
sq_out  output  1  registered square wave
busy  output  1  high in RUN or PAUSE
done  output  1  high in DONE
state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3
tick_cnt  output  16  number of ticks since the last start from IDLE/DONE; wraps at 65535->0

Behaviour:
- Reset values: state=IDLE, cnt=0, period_r=DEFAULT_PERIOD, pend_valid=0, tick=0, sq_out=0, busy=0, done=0, tick_cnt=0, mode=0. Reset is asynchronous and takes effect at any point mid-operation, including mid-period and mid-tick.
- Priority within one edge: stop > pause > start.
- Period load:
  - In IDLE or DONE: period_r <= max(period_in,1) on the same edge.
  - In RUN or PAUSE: the value goes to pend_r and pend_valid=1. It is applied at the next wrap. A later load before the wrap overwrites pend_r.
  - A stop in RUN/PAUSE also applies a pending value, then clears pend_valid.
- IDLE:
  - start -> RUN; cnt=0; tick_cnt=0; mode<=oneshot.
- RUN:
  - cnt increments each advance.
  - Terminal count is cnt==period_r-1. On the terminal-count edge: cnt<=0, tick<=1, tick_cnt++, and the pending period is applied.
  - If mode=1 on that edge, next state is DONE.
  - pause -> PAUSE; cnt and sq_out hold; no tick.
  - stop -> IDLE; cnt=0. A stop on the terminal-count edge suppresses the tick.
- PAUSE:
  - start (with no stop or pause asserted) -> RUN; counting resumes from the held cnt.
  - stop -> IDLE.
- DONE:
  - done=1.
  - start -> RUN with cnt=0, tick_cnt=0 and mode re-latched.
  - stop -> IDLE.
- Latency: start sampled at edge E0 puts state=RUN with cnt=0. With period P and PRESCALE=1, tick is high for exactly the one cycle following edge E0+P; subsequent ticks follow every P cycles.
- period_r=1: tick is asserted on every RUN cycle and sq_out=1 constantly.
- sq_out:
  - In RUN, registered as (next cnt < period_r/2), using integer division.
  - In PAUSE it holds its value.
  - In IDLE and DONE it is 0.
  - P=4 gives 1,1,0,0. Odd P has the high phase shorter by one.
- tick is never high for two consecutive cycles unless period_r=1.
- busy and done are registered decodes of state.

Optional Feature:
TICK_PRESCALE_EN:
- Defined: an internal prescaler counter (8 bit) generates adv once every PRESCALE clk cycles. cnt, terminal count and sq_out update only on adv edges.
  - tick stays exactly one clk wide.
  - The prescaler clears on start from IDLE/DONE and on stop, and holds in PAUSE.
  - Tick interval = P*PRESCALE cycles.
- Not defined: no prescaler logic; adv is constant 1 and the PRESCALE parameter is ignored.

Test Plan:
- Reset, load period_in=5, start held one cycle, oneshot=0 -> ticks 5 cycles after the start edge, then every 5 cycles; tick_cnt 1,2,3; sq_out pattern 1,1,0,0,0.
- oneshot=1, P=3, start -> single tick 3 cycles after start; state=DONE, done=1, tick_cnt=1; no further ticks over 20 cycles.
- P=10 running; pause asserted at cnt=4 for 7 cycles, then start -> state=PAUSE, cnt held at 4; next tick 6 cycles after resume; no tick during pause.
- P=8 running; load period_in=3 at cnt=2 -> current period completes at 8 cycles; following ticks every 3 cycles. load period_in=0 in IDLE -> period_r=1, tick every cycle.
- stop asserted on the terminal-count cycle -> no tick, state=IDLE, cnt=0, sq_out=0. rst_n asserted low mid-period -> all outputs at reset values immediately, without waiting for a clk edge.
- With TICK_PRESCALE_EN defined, PRESCALE=4, P=2 -> tick every 8 clk, each 1 clk wide.
